// File: rtl/sysid_reader_pkg.sv
// Shared definitions for the system-ID checker: Avalon word addresses,
// default expected words used by system integration, and FSM state codes.
package sysid_reader_pkg;

  localparam logic [31:0] SYSID_EXPECTED_ID        = 32'd0;
  localparam logic [31:0] SYSID_EXPECTED_TIMESTAMP = 32'd1361149627;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  typedef logic [2:0] sysid_state_t;

  localparam sysid_state_t ST_IDLE   = 3'd0;
  localparam sysid_state_t ST_RD_ID  = 3'd1;
  localparam sysid_state_t ST_LAT_ID = 3'd2;
  localparam sysid_state_t ST_RD_TS  = 3'd3;
  localparam sysid_state_t ST_LAT_TS = 3'd4;
  localparam sysid_state_t ST_DONE   = 3'd5;

  function automatic logic word_match(input logic [31:0] actual, input logic [31:0] expected);
    return (actual == expected);
  endfunction

endpackage

// File: rtl/sysid_reader.sv
// Avalon-MM read master that fetches the system ID and build timestamp from a
// sysid slave, compares them with expected values and reports the verdict.
module sysid_reader
  import sysid_reader_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = SYSID_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TIMESTAMP = SYSID_EXPECTED_TIMESTAMP,
  parameter int unsigned READ_LATENCY       = 0,
  parameter int unsigned TIMEOUT_CYCLES     = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        address,
  output logic        read,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic [31:0] id_value,
  output logic [31:0] timestamp_value,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout
);

  localparam logic [2:0]  LAT_LAST   = (READ_LATENCY > 0) ? 3'(READ_LATENCY - 1) : 3'd0;
  localparam logic [15:0] STALL_LAST = 16'(TIMEOUT_CYCLES - 1);

  sysid_state_t state_r;
  logic         auto_start_r;
  logic [2:0]   lat_cnt_r;
  logic [15:0]  stall_cnt_r;

  logic accept_s;
  logic stall_limit_s;
  logic lat_last_s;
  logic launch_s;

  // Decode handshake, stall-limit, latency and launch conditions for this cycle.
  always_comb begin
    accept_s      = read & ~waitrequest;
    stall_limit_s = read & waitrequest & (stall_cnt_r == STALL_LAST);
    lat_last_s    = (lat_cnt_r == LAT_LAST);
    launch_s      = auto_start_r | start;
  end

  // Sequencer: issues both reads, captures data, tracks stalls and registers the verdict.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r         <= ST_IDLE;
      auto_start_r    <= 1'b1;
      lat_cnt_r       <= 3'd0;
      stall_cnt_r     <= 16'd0;
      address         <= SYSID_ADDR_ID;
      read            <= 1'b0;
      id_value        <= 32'd0;
      timestamp_value <= 32'd0;
      busy            <= 1'b0;
      done            <= 1'b0;
      id_ok           <= 1'b0;
      ts_ok           <= 1'b0;
      timeout         <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          // Captured words are cleared so a timed-out read always reports zero.
          if (launch_s) begin
            state_r         <= ST_RD_ID;
            auto_start_r    <= 1'b0;
            lat_cnt_r       <= 3'd0;
            stall_cnt_r     <= 16'd0;
            address         <= SYSID_ADDR_ID;
            read            <= 1'b1;
            id_value        <= 32'd0;
            timestamp_value <= 32'd0;
            busy            <= 1'b1;
            done            <= 1'b0;
            id_ok           <= 1'b0;
            ts_ok           <= 1'b0;
            timeout         <= 1'b0;
          end
        end
        ST_RD_ID: begin
          if (accept_s) begin
            stall_cnt_r <= 16'd0;
            if (READ_LATENCY == 0) begin
              id_value <= readdata;
              address  <= SYSID_ADDR_TS;
              state_r  <= ST_RD_TS;
            end else begin
              read      <= 1'b0;
              lat_cnt_r <= 3'd0;
              state_r   <= ST_LAT_ID;
            end
          end else if (stall_limit_s) begin
            stall_cnt_r <= 16'd0;
            read        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            timeout     <= 1'b1;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            state_r     <= ST_DONE;
          end else begin
            stall_cnt_r <= stall_cnt_r + 16'd1;
          end
        end
        ST_LAT_ID: begin
          if (lat_last_s) begin
            id_value <= readdata;
            address  <= SYSID_ADDR_TS;
            read     <= 1'b1;
            state_r  <= ST_RD_TS;
          end else begin
            lat_cnt_r <= lat_cnt_r + 3'd1;
          end
        end
        ST_RD_TS: begin
          if (accept_s) begin
            stall_cnt_r <= 16'd0;
            if (READ_LATENCY == 0) begin
              timestamp_value <= readdata;
              read            <= 1'b0;
              busy            <= 1'b0;
              done            <= 1'b1;
              id_ok           <= word_match(id_value, EXPECTED_ID);
              ts_ok           <= word_match(readdata, EXPECTED_TIMESTAMP);
              state_r         <= ST_DONE;
            end else begin
              read      <= 1'b0;
              lat_cnt_r <= 3'd0;
              state_r   <= ST_LAT_TS;
            end
          end else if (stall_limit_s) begin
            stall_cnt_r <= 16'd0;
            read        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            timeout     <= 1'b1;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            state_r     <= ST_DONE;
          end else begin
            stall_cnt_r <= stall_cnt_r + 16'd1;
          end
        end
        ST_LAT_TS: begin
          if (lat_last_s) begin
            timestamp_value <= readdata;
            busy            <= 1'b0;
            done            <= 1'b1;
            id_ok           <= word_match(id_value, EXPECTED_ID);
            ts_ok           <= word_match(readdata, EXPECTED_TIMESTAMP);
            state_r         <= ST_DONE;
          end else begin
            lat_cnt_r <= lat_cnt_r + 3'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          read    <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_reader.sv
// Bench for sysid_reader: zero-latency instance with stall responder (timeout 4)
// and a latency-2 instance whose responder drives junk outside the data cycle.
module tb_sysid_reader;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1361149627;
  localparam int          TO_A   = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic        address_a, read_a, busy_a, done_a, id_ok_a, ts_ok_a, timeout_a;
  logic        address_b, read_b, busy_b, done_b, id_ok_b, ts_ok_b, timeout_b;
  logic        wr_a = 1'b0, wr_b = 1'b0;
  logic [31:0] rd_a = 32'd0, rd_b = 32'hDEADBEEF;
  logic [31:0] id_value_a, timestamp_value_a, id_value_b, timestamp_value_b;

  logic [31:0] mem_a0 = 32'd0, mem_a1 = 32'd0, mem_b0 = 32'd0, mem_b1 = 32'd0;
  int          stall_a0 = 0, stall_a1 = 0, cnt_a = 0;
  logic        prev_addr_a = 1'b0;
  logic        acc_valid_b = 1'b0, acc_addr_b = 1'b0;
  int          acc_age_b = 0;

  int checks = 0;
  int errors = 0;

  sysid_reader #(.READ_LATENCY(0), .TIMEOUT_CYCLES(TO_A)) dut_a (
    .clock(clock), .reset_n(reset_n), .start(start_a), .address(address_a), .read(read_a),
    .waitrequest(wr_a), .readdata(rd_a), .id_value(id_value_a), .timestamp_value(timestamp_value_a),
    .busy(busy_a), .done(done_a), .id_ok(id_ok_a), .ts_ok(ts_ok_a), .timeout(timeout_a));

  sysid_reader #(.READ_LATENCY(2), .TIMEOUT_CYCLES(255)) dut_b (
    .clock(clock), .reset_n(reset_n), .start(start_b), .address(address_b), .read(read_b),
    .waitrequest(wr_b), .readdata(rd_b), .id_value(id_value_b), .timestamp_value(timestamp_value_b),
    .busy(busy_b), .done(done_b), .id_ok(id_ok_b), .ts_ok(ts_ok_b), .timeout(timeout_b));

  initial forever #5 clock = ~clock;

  // Responder A: stalls each read for a programmable number of cycles, data valid on accept.
  always @(negedge clock) begin
    if (!read_a || address_a != prev_addr_a) cnt_a = 0;
    prev_addr_a = address_a;
    rd_a = address_a ? mem_a1 : mem_a0;
    if (read_a && cnt_a < (address_a ? stall_a1 : stall_a0)) begin
      wr_a = 1'b1;
      cnt_a++;
    end else begin
      wr_a = 1'b0;
    end
  end

  // Responder B: data valid only in the second cycle after the accept, junk otherwise.
  always @(posedge clock) begin
    if (!reset_n) begin
      acc_valid_b = 1'b0;
    end else if (read_b && !wr_b) begin
      acc_valid_b = 1'b1;
      acc_addr_b  = address_b;
      acc_age_b   = 0;
    end else begin
      acc_age_b++;
    end
  end
  always @(negedge clock)
    rd_b = (acc_valid_b && acc_age_b == 1) ? (acc_addr_b ? mem_b1 : mem_b0) : 32'hDEADBEEF;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: read k costs (stall+1) cycles; a stall of TO_A or more aborts after TO_A cycles.
  function automatic void ref_model(input int s0, input int s1, input logic [31:0] v0, input logic [31:0] v1,
                                    output int cyc, output logic [31:0] id, output logic [31:0] ts,
                                    output logic [2:0] flags);
    if (s0 >= TO_A) begin
      cyc = TO_A; id = 32'd0; ts = 32'd0; flags = 3'b001;
    end else if (s1 >= TO_A) begin
      cyc = s0 + 1 + TO_A; id = v0; ts = 32'd0; flags = 3'b001;
    end else begin
      cyc = s0 + s1 + 2; id = v0; ts = v1;
      flags = {v0 == EXP_ID, v1 == EXP_TS, 1'b0};
    end
  endfunction

  task automatic run_a(input int s0, input int s1, input logic [31:0] v0, input logic [31:0] v1,
                       output int cyc, output logic stable);
    logic pr, pa;
    stall_a0 = s0; stall_a1 = s1; mem_a0 = v0; mem_a1 = v1;
    @(negedge clock); start_a = 1'b1;
    @(posedge clock); #1 start_a = 1'b0;
    pr = read_a; pa = address_a; cyc = 0; stable = 1'b1;
    while (!done_a && cyc < 60) begin
      @(posedge clock); #1;
      cyc++;
      if (wr_a && !done_a && (read_a !== pr || address_a !== pa)) stable = 1'b0;
      pr = read_a; pa = address_a;
    end
  endtask

  task automatic verify_a(input string name, input int cyc, input logic stable, input int e_cyc,
                          input logic [31:0] e_id, input logic [31:0] e_ts, input logic [2:0] e_flags);
    chk({name, "_cycles"}, cyc, e_cyc);
    chk({name, "_id"}, id_value_a, e_id);
    chk({name, "_ts"}, timestamp_value_a, e_ts);
    chk({name, "_flags"}, {id_ok_a, ts_ok_a, timeout_a}, e_flags);
    chk({name, "_busy_done"}, {busy_a, done_a}, 2'b01);
    chk({name, "_stable"}, stable, 1'b1);
  endtask

  typedef struct {
    int          s0, s1;
    logic [31:0] v0, v1;
    int          cyc;
    logic [31:0] id, ts;
    logic [2:0]  flags;
  } scen_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
  } cyc_t;

  scen_t tbl[7];
  cyc_t  seq[7];

  initial begin
    int n, cyc, e_cyc;
    logic stable;
    logic [31:0] v0, v1, e_id, e_ts;
    logic [2:0] e_flags;
    int s0, s1;

    tbl[0] = '{0, 0, 32'd0, EXP_TS, 2, 32'd0, EXP_TS, 3'b110};
    tbl[1] = '{0, 0, 32'd0, 32'd1361149628, 2, 32'd0, 32'd1361149628, 3'b100};
    tbl[2] = '{3, 3, 32'd0, EXP_TS, 8, 32'd0, EXP_TS, 3'b110};
    tbl[3] = '{0, 2, 32'h0000_1234, EXP_TS, 4, 32'h0000_1234, EXP_TS, 3'b010};
    tbl[4] = '{4, 0, 32'hAAAA_0000, EXP_TS, 4, 32'd0, 32'd0, 3'b001};
    tbl[5] = '{2, 9, 32'h0000_0055, EXP_TS, 7, 32'h0000_0055, 32'd0, 3'b001};
    tbl[6] = '{1, 0, 32'd0, 32'hFFFF_FFFF, 3, 32'd0, 32'hFFFF_FFFF, 3'b100};
    // {busy, read, read&address, done} per cycle after reset release
    seq[0] = '{4'b1100, 4'b1100};
    seq[1] = '{4'b1110, 4'b1000};
    seq[2] = '{4'b0001, 4'b1000};
    seq[3] = '{4'b0001, 4'b1110};
    seq[4] = '{4'b0001, 4'b1000};
    seq[5] = '{4'b0001, 4'b1000};
    seq[6] = '{4'b0001, 4'b0001};

    // Power-on: reset values, then auto-start timing for both instances.
    mem_a0 = EXP_ID; mem_a1 = EXP_TS; mem_b0 = EXP_ID; mem_b1 = EXP_TS;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_ctl_a", {address_a, read_a, busy_a, done_a, id_ok_a, ts_ok_a, timeout_a}, 7'd0);
    chk("reset_val_a", id_value_a | timestamp_value_a, 32'd0);
    chk("reset_ctl_b", {address_b, read_b, busy_b, done_b, id_ok_b, ts_ok_b, timeout_b}, 7'd0);
    @(negedge clock); reset_n = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(posedge clock); #1;
      chk($sformatf("boot_a_c%0d", k + 1), {busy_a, read_a, read_a & address_a, done_a}, seq[k].a);
      chk($sformatf("boot_b_c%0d", k + 1), {busy_b, read_b, read_b & address_b, done_b}, seq[k].b);
    end
    chk("boot_a_flags", {id_ok_a, ts_ok_a, timeout_a}, 3'b110);
    chk("boot_a_ts", timestamp_value_a, EXP_TS);
    chk("boot_b_id", id_value_b, EXP_ID);
    chk("boot_b_ts", timestamp_value_b, EXP_TS);
    chk("boot_b_flags", {id_ok_b, ts_ok_b, timeout_b}, 3'b110);

    // Latency instance rerun with mismatching words.
    mem_b0 = 32'h0000_0042; mem_b1 = 32'd1361149628;
    @(negedge clock); start_b = 1'b1;
    @(posedge clock); #1 start_b = 1'b0;
    n = 0;
    while (!done_b && n < 30) begin @(posedge clock); #1; n++; end
    chk("lat_rerun_cycles", n, 6);
    chk("lat_rerun_id", id_value_b, 32'h0000_0042);
    chk("lat_rerun_ts", timestamp_value_b, 32'd1361149628);
    chk("lat_rerun_flags", {id_ok_b, ts_ok_b, timeout_b}, 3'b000);

    // Table-driven scenarios on the stall-capable instance.
    for (int i = 0; i < 7; i++) begin
      run_a(tbl[i].s0, tbl[i].s1, tbl[i].v0, tbl[i].v1, cyc, stable);
      verify_a($sformatf("tbl%0d", i), cyc, stable, tbl[i].cyc, tbl[i].id, tbl[i].ts, tbl[i].flags);
    end

    // start while busy must be neither honoured nor queued.
    stall_a0 = 3; stall_a1 = 3; mem_a0 = EXP_ID; mem_a1 = EXP_TS;
    @(negedge clock); start_a = 1'b1;
    @(posedge clock); #1 start_a = 1'b0;
    n = 0;
    repeat (3) begin @(posedge clock); #1; n++; end
    start_a = 1'b1;
    @(posedge clock); #1 start_a = 1'b0; n++;
    while (!done_a && n < 40) begin @(posedge clock); #1; n++; end
    chk("busy_start_cycles", n, 8);
    repeat (3) @(posedge clock);
    #1;
    chk("busy_start_not_queued", {busy_a, done_a, read_a}, 3'b010);
    chk("busy_start_flags", {id_ok_a, ts_ok_a, timeout_a}, 3'b110);

    // Asynchronous reset while the timestamp read is stalled.
    stall_a0 = 0; stall_a1 = 3; mem_a0 = 32'h0000_0077; mem_a1 = EXP_TS;
    @(negedge clock); start_a = 1'b1;
    @(posedge clock); #1 start_a = 1'b0;
    @(posedge clock); #1;
    chk("mid_rd_ts", {read_a, address_a, busy_a}, 3'b111);
    chk("mid_id_captured", id_value_a, 32'h0000_0077);
    reset_n = 1'b0;
    #1;
    chk("async_rst_ctl", {address_a, read_a, busy_a, done_a, id_ok_a, ts_ok_a, timeout_a}, 7'd0);
    chk("async_rst_val", id_value_a | timestamp_value_a, 32'd0);
    mem_a0 = EXP_ID; stall_a1 = 0; mem_b0 = EXP_ID; mem_b1 = EXP_TS;
    @(negedge clock); @(negedge clock); reset_n = 1'b1;
    n = 0;
    while (!(done_a && done_b) && n < 30) begin @(posedge clock); #1; n++; end
    chk("rerun_cycles", n, 7);
    chk("rerun_a_flags", {busy_a, done_a, id_ok_a, ts_ok_a, timeout_a}, 5'b01110);
    chk("rerun_a_ts", timestamp_value_a, EXP_TS);
    chk("rerun_b_flags", {busy_b, done_b, id_ok_b, ts_ok_b, timeout_b}, 5'b01110);

    // Randomized runs against the reference model.
    for (int i = 0; i < 40; i++) begin
      s0 = $urandom_range(0, 5);
      s1 = $urandom_range(0, 5);
      v0 = ($urandom_range(0, 1) == 0) ? EXP_ID : $urandom;
      v1 = ($urandom_range(0, 1) == 0) ? EXP_TS : $urandom;
      ref_model(s0, s1, v0, v1, e_cyc, e_id, e_ts, e_flags);
      run_a(s0, s1, v0, v1, cyc, stable);
      verify_a($sformatf("rnd%0d", i), cyc, stable, e_cyc, e_id, e_ts, e_flags);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sysid_reader.md
Name: sysid_reader

Overview:
Avalon-MM read master that interrogates a system-ID slave. It reads address 0 (system ID) and address 1 (build timestamp), then compares both against expected values. It runs automatically after reset and again on each start pulse. It reports captured values and pass/fail/timeout flags, which gate software boot and drive a status LED in the Nios control subsystem.

Parameters:
EXPECTED_ID, 32'd0, value required at address 0
EXPECTED_TIMESTAMP, 32'd1361149627, value required at address 1
READ_LATENCY, 0, cycles from accepted read to valid readdata (0 = readdata valid in the accept cycle); range 0..7
TIMEOUT_CYCLES, 255, consecutive waitrequest-high cycles tolerated per read; range 1..65535

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request to re-run the check; ignored while busy=1
address  out  1  Avalon word address to slave
read  out  1  Avalon read strobe
waitrequest  in  1  slave stall; tie 0 for zero-wait slaves
readdata  in  32  slave read data
id_value  out  32  captured word from address 0
timestamp_value  out  32  captured word from address 1
busy  out  1  sequence in progress
done  out  1  sequence complete, results valid (level, held)
id_ok  out  1  id_value == EXPECTED_ID
ts_ok  out  1  timestamp_value == EXPECTED_TIMESTAMP
timeout  out  1  a read exceeded TIMEOUT_CYCLES

Behaviour:
- One clock; reset is asynchronous and active-low (clock, reset_n). All outputs are registered.
- Reset values: address=0, read=0, busy=0, done=0, id_ok=0, ts_ok=0, timeout=0, id_value=0, timestamp_value=0, state=IDLE, internal auto_start=1.
- States: IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, DONE.
- IDLE: when auto_start or start, go to RD_ID, clear auto_start, set busy=1, clear done/ok/timeout flags.
- RD_ID: read=1, address=0. A read is accepted on an edge where read=1 and waitrequest=0.
  - READ_LATENCY=0: capture readdata into id_value on the accept edge, then go to RD_TS.
  - READ_LATENCY>0: on accept, read drops to 0 and the block enters LAT_ID with lat_cnt=0.
- LAT_ID: increment lat_cnt each cycle. Capture readdata on the edge where lat_cnt==READ_LATENCY-1, then go to RD_TS.
- RD_TS/LAT_TS: same as RD_ID/LAT_ID with address=1, capturing into timestamp_value, then go to DONE.
- No back-to-back pipelining: read is 0 for at least the cycle after each accept unless READ_LATENCY=0. With READ_LATENCY=0, read stays 1 while address changes 0→1.
- Timing with zero-wait and READ_LATENCY=0: read is high for cycles 1–2 after the first post-reset edge, and done=1 from cycle 3.
- DONE: read=0, busy=0, done=1. id_ok and ts_ok are registered compares of the captured values and update on the DONE entry edge. Flags hold until the next start. A start in DONE behaves as in IDLE, returning to RD_ID.
- Timeout: a 16-bit stall counter increments on each RD_* cycle with waitrequest=1 and clears on accept or state change. When it reaches TIMEOUT_CYCLES: read=0, timeout=1, id_ok=ts_ok=0, go to DONE. Values not yet captured remain 0.
- start while busy=1 is ignored (not queued).
- Asynchronous reset mid-sequence aborts immediately to reset values; auto_start=1 re-runs the sequence after release.
- address and read change only on clock edges and are held stable while waitrequest=1 (Avalon compliance).

Decomposition:
- Package sysid_reader_pkg: state enum, SYSID_ADDR_ID=1'b0, SYSID_ADDR_TS=1'b1, default EXPECTED_* constants shared with system integration.
- No sub-module required. The read/latency/timeout sequencing may optionally be factored into avalon_single_read (one address, one capture) and instantiated once with an address mux.

Test Plan:
- Zero-wait responder (addr0→0, addr1→1361149627), READ_LATENCY=0, reset release → read high in cycles 1–2; done=1 at cycle 3; id_ok=1, ts_ok=1; id_value=0, timestamp_value=1361149627.
- Responder returns 1361149628 at addr1 → done=1, id_ok=1, ts_ok=0, timestamp_value=1361149628.
- waitrequest held high 3 cycles on each read → address/read stable throughout; done at cycle 9; both ok=1.
- READ_LATENCY=2, data presented 2 cycles after accept → correct capture; wrong-cycle data (driven as 32'hDEADBEEF) is not captured.
- waitrequest stuck high, TIMEOUT_CYCLES=4 → read drops after 4 stalled cycles; timeout=1, done=1, id_ok=ts_ok=0, busy=0.
- start pulsed mid-sequence → ignored. reset_n low during RD_TS → outputs return to reset values immediately; after release the full sequence reruns and passes.
